// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounced single-capture and a CPU read port.
// Debounce over DEBOUNCE_SCANS scans is enabled by defining KEYPAD_DEBOUNCE_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  rowwrite,
  input  logic [3:0]  colread,
  input  logic        ack,
  input  logic        statusordata,
  output logic [15:0] keyout
);

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int unsigned NumScans = (DEBOUNCE_SCANS < 1) ? 1 : DEBOUNCE_SCANS;
`else
  localparam int unsigned NumScans = 1;
`endif

  localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam int unsigned CntW = $clog2(NumScans + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(NumScans);

  typedef enum logic [0:0] {StArmed, StHeld} arm_state_e;

  logic [DivW-1:0] div_q;
  logic [1:0]      row_q;
  logic            hit_q;
  logic [3:0]      hit_idx_q;

  logic            last_hit_q, last_hit_d;
  logic [3:0]      last_idx_q, last_idx_d;
  logic [CntW-1:0] press_cnt_q, press_cnt_d;
  logic [CntW-1:0] none_cnt_q, none_cnt_d;
  arm_state_e      state_q, state_d;

  logic            ready_q;
  logic [3:0]      keycode_q;
  logic            ack_prev_q;

  logic            slot_end;
  logic            scan_end;
  logic [3:0]      col_low;
  logic            row_hit;
  logic [1:0]      row_col;
  logic            scan_hit;
  logic [3:0]      scan_idx;
  logic [3:0]      scan_code;
  logic            capture;

  assign slot_end = (div_q == DivLast);
  assign scan_end = slot_end && (row_q == 2'd3);
  assign col_low  = ~colread;
  assign row_hit  = |col_low;

  always_comb begin
    row_col = 2'd0;
    if (col_low[0])      row_col = 2'd0;
    else if (col_low[1]) row_col = 2'd1;
    else if (col_low[2]) row_col = 2'd2;
    else if (col_low[3]) row_col = 2'd3;
  end

  // An earlier row already holding a hit wins, so scan order decides priority.
  assign scan_hit = hit_q | row_hit;
  assign scan_idx = hit_q ? hit_idx_q : {row_q, row_col};

  always_comb begin
    rowwrite = 4'b1110;
    unique case (row_q)
      2'd0: rowwrite = 4'b1110;
      2'd1: rowwrite = 4'b1101;
      2'd2: rowwrite = 4'b1011;
      2'd3: rowwrite = 4'b0111;
      default: rowwrite = 4'b1110;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      row_q     <= 2'd0;
      hit_q     <= 1'b0;
      hit_idx_q <= 4'd0;
    end else if (slot_end) begin
      div_q <= '0;
      row_q <= row_q + 2'd1;
      if (scan_end) begin
        hit_q     <= 1'b0;
        hit_idx_q <= 4'd0;
      end else if (!hit_q && row_hit) begin
        hit_q     <= 1'b1;
        hit_idx_q <= {row_q, row_col};
      end
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_comb begin
    scan_code = 4'h0;
    unique case (scan_idx)
      4'd0:  scan_code = 4'h1;
      4'd1:  scan_code = 4'h2;
      4'd2:  scan_code = 4'h3;
      4'd3:  scan_code = 4'hA;
      4'd4:  scan_code = 4'h4;
      4'd5:  scan_code = 4'h5;
      4'd6:  scan_code = 4'h6;
      4'd7:  scan_code = 4'hB;
      4'd8:  scan_code = 4'h7;
      4'd9:  scan_code = 4'h8;
      4'd10: scan_code = 4'h9;
      4'd11: scan_code = 4'hC;
      4'd12: scan_code = 4'hE;
      4'd13: scan_code = 4'h0;
      4'd14: scan_code = 4'hF;
      4'd15: scan_code = 4'hD;
      default: scan_code = 4'h0;
    endcase
  end

  // Run-length counters saturate at the threshold; only the armed state may capture.
  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    none_cnt_d  = none_cnt_q;
    last_hit_d  = last_hit_q;
    last_idx_d  = last_idx_q;
    capture     = 1'b0;
    if (scan_end) begin
      if (scan_hit) begin
        none_cnt_d = '0;
        last_hit_d = 1'b1;
        last_idx_d = scan_idx;
        if (!last_hit_q || (last_idx_q != scan_idx)) begin
          press_cnt_d = CntW'(1);
        end else if (press_cnt_q != CntMax) begin
          press_cnt_d = press_cnt_q + 1'b1;
        end
      end else begin
        press_cnt_d = '0;
        last_hit_d  = 1'b0;
        if (none_cnt_q != CntMax) begin
          none_cnt_d = none_cnt_q + 1'b1;
        end
      end
      unique case (state_q)
        StArmed: begin
          if (scan_hit && (press_cnt_d == CntMax)) begin
            capture = 1'b1;
            state_d = StHeld;
          end
        end
        StHeld: begin
          if (!scan_hit && (none_cnt_d == CntMax)) begin
            state_d = StArmed;
          end
        end
        default: state_d = StArmed;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StArmed;
      press_cnt_q <= '0;
      none_cnt_q  <= '0;
      last_hit_q  <= 1'b0;
      last_idx_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      none_cnt_q  <= none_cnt_d;
      last_hit_q  <= last_hit_d;
      last_idx_q  <= last_idx_d;
    end
  end

  // Capture takes priority over an ack rising edge in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q    <= 1'b0;
      keycode_q  <= 4'h0;
      ack_prev_q <= 1'b0;
    end else begin
      ack_prev_q <= ack;
      if (capture) begin
        ready_q   <= 1'b1;
        keycode_q <= scan_code;
      end else if (ack && !ack_prev_q) begin
        ready_q <= 1'b0;
      end
    end
  end

  assign keyout = statusordata ? {15'd0, ready_q} : {12'd0, keycode_q};

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives colread and a
// scan-level reference model predicts ready/keycode every cycle.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DS = 2;
  localparam int SCAN = 4 * SD;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int NEFF = DS;
`else
  localparam int NEFF = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ack;
  logic        statusordata;
  logic [3:0]  rowwrite;
  logic [3:0]  colread;
  logic [15:0] keyout;
  logic [15:0] keys;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_edges;
  bit         m_ready;
  logic [3:0] m_code;
  bit         m_armed;
  int         m_press_run;
  int         m_none_run;
  int         m_last;
  bit         m_ack_prev;

  logic [3:0] code_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk          (clk),
    .reset        (reset),
    .rowwrite     (rowwrite),
    .colread      (colread),
    .ack          (ack),
    .statusordata (statusordata),
    .keyout       (keyout)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a pressed key shorts its column to the low row.
  always_comb begin
    colread = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!rowwrite[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[4*r+c]) colread[c] = 1'b0;
        end
      end
    end
  end

  function automatic int lowest(input logic [15:0] k);
    for (int i = 0; i < 16; i++) if (k[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] exp_row();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((m_edges / SD) % 4));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edges = 0; m_ready = 0; m_code = 4'h0; m_armed = 1;
      m_press_run = 0; m_none_run = 0; m_last = -1; m_ack_prev = 0;
    end else begin
      bit cap;
      int res;
      cap = 0;
      m_edges++;
      if (m_edges % SCAN == 0) begin
        res = lowest(keys);
        if (res >= 0) begin
          m_none_run  = 0;
          m_press_run = (res == m_last) ? m_press_run + 1 : 1;
          m_last      = res;
          if (m_armed && m_press_run >= NEFF) begin
            cap = 1; m_armed = 0; m_code = code_map[res];
          end
        end else begin
          m_press_run = 0; m_last = -1; m_none_run++;
          if (!m_armed && m_none_run >= NEFF) m_armed = 1;
        end
      end
      if (cap) m_ready = 1;
      else if (ack && !m_ack_prev) m_ready = 0;
      m_ack_prev = ack;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic to_boundary();
    while (m_edges % SCAN != 0) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ack = 1'b0; statusordata = 1'b0; keys = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if (rowwrite !== 4'b1110) begin
      errors++; $display("FAIL reset_row: rowwrite=%b expected=1110", rowwrite);
    end
    statusordata = 1'b1; #1;
    checks++;
    if (keyout !== 16'h0000) begin
      errors++; $display("FAIL reset_status: keyout=%h expected=0000", keyout);
    end
    statusordata = 1'b0; #1;
    checks++;
    if (keyout !== 16'h0000) begin
      errors++; $display("FAIL reset_data: keyout=%h expected=0000", keyout);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_scan_rows();
    for (int i = 0; i < 2 * SCAN; i++) begin
      tick();
      checks++;
      if (rowwrite !== exp_row()) begin
        errors++; $display("FAIL scan_rows: rowwrite=%b expected=%b", rowwrite, exp_row());
      end
      statusordata = 1'b1; #1;
      checks++;
      if (keyout !== 16'h0000) begin
        errors++; $display("FAIL idle_status: keyout=%h expected=0000", keyout);
      end
      statusordata = 1'b0; #1;
      checks++;
      if (keyout !== 16'h0000) begin
        errors++; $display("FAIL idle_data: keyout=%h expected=0000", keyout);
      end
    end
  endtask

  task automatic test_capture();
    to_boundary();
    keys = 16'h0040;
    for (int i = 0; i < 3 * SCAN; i++) begin
      tick();
      statusordata = 1'b1; #1;
      checks++;
      if (keyout !== {15'd0, m_ready}) begin
        errors++; $display("FAIL capture_status: keyout=%h expected=%h", keyout, {15'd0, m_ready});
      end
      statusordata = 1'b0; #1;
      checks++;
      if (keyout !== {12'd0, m_code}) begin
        errors++; $display("FAIL capture_data: keyout=%h expected=%h", keyout, {12'd0, m_code});
      end
    end
    statusordata = 1'b1; #1;
    checks++;
    if (keyout !== 16'h0001) begin
      errors++; $display("FAIL six_ready: keyout=%h expected=0001", keyout);
    end
    statusordata = 1'b0; #1;
    checks++;
    if (keyout !== 16'h0006) begin
      errors++; $display("FAIL six_code: keyout=%h expected=0006", keyout);
    end
  endtask

  task automatic test_ack();
    ack = 1'b1;
    tick();
    statusordata = 1'b1; #1;
    checks++;
    if (keyout !== 16'h0000) begin
      errors++; $display("FAIL ack_clear: keyout=%h expected=0000", keyout);
    end
    statusordata = 1'b0;
    for (int i = 0; i < 9 + 2 * SCAN; i++) begin
      if (i == 9) ack = 1'b0;
      tick();
      statusordata = 1'b1; #1;
      checks++;
      if (keyout !== {15'd0, m_ready}) begin
        errors++; $display("FAIL ack_status: keyout=%h expected=%h", keyout, {15'd0, m_ready});
      end
      statusordata = 1'b0; #1;
      checks++;
      if (keyout !== 16'h0006) begin
        errors++; $display("FAIL ack_hold_data: keyout=%h expected=0006", keyout);
      end
    end
  endtask

  task automatic test_star_and_multi();
    to_boundary();
    keys = 16'h0000;
    repeat (2 * SCAN) tick();
    keys = 16'h1000;
    repeat (2 * SCAN) tick();
    statusordata = 1'b1; #1;
    checks++;
    if (keyout !== 16'h0001) begin
      errors++; $display("FAIL star_ready: keyout=%h expected=0001", keyout);
    end
    statusordata = 1'b0; #1;
    checks++;
    if (keyout !== 16'h000E) begin
      errors++; $display("FAIL star_code: keyout=%h expected=000e", keyout);
    end
    keys = 16'h0000;
    repeat (2 * SCAN) tick();
    keys = 16'h4001;
    repeat (2 * SCAN) tick();
    #1;
    checks++;
    if (keyout !== 16'h0001) begin
      errors++; $display("FAIL multi_code: keyout=%h expected=0001", keyout);
    end
  endtask

  task automatic test_reset_mid_debounce();
    to_boundary();
    keys = 16'h0000;
    repeat (2 * SCAN) tick();
    keys = 16'h0020;
    repeat (SCAN + 5) tick();
    reset = 1'b1; #1;
    checks++;
    if (rowwrite !== 4'b1110) begin
      errors++; $display("FAIL midreset_row: rowwrite=%b expected=1110", rowwrite);
    end
    statusordata = 1'b1; #1;
    checks++;
    if (keyout !== 16'h0000) begin
      errors++; $display("FAIL midreset_status: keyout=%h expected=0000", keyout);
    end
    statusordata = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < DS * SCAN; i++) begin
      tick();
      statusordata = 1'b1; #1;
      checks++;
      if (keyout !== {15'd0, m_ready}) begin
        errors++; $display("FAIL after_reset_status: keyout=%h expected=%h", keyout, {15'd0, m_ready});
      end
      statusordata = 1'b0; #1;
      checks++;
      if (keyout !== {12'd0, m_code}) begin
        errors++; $display("FAIL after_reset_data: keyout=%h expected=%h", keyout, {12'd0, m_code});
      end
    end
    checks++;
    if (keyout !== 16'h0005) begin
      errors++; $display("FAIL five_code: keyout=%h expected=0005", keyout);
    end
  endtask

  task automatic test_bounce();
    to_boundary();
    keys = 16'h0000;
    repeat (2 * SCAN) tick();
    keys = 16'h0400;
    for (int i = 0; i < 3 * SCAN; i++) begin
      if (i == SCAN) keys = 16'h0000;
      tick();
      statusordata = 1'b1; #1;
      checks++;
      if (keyout !== {15'd0, m_ready}) begin
        errors++; $display("FAIL bounce_status: keyout=%h expected=%h", keyout, {15'd0, m_ready});
      end
      statusordata = 1'b0; #1;
      checks++;
      if (keyout !== {12'd0, m_code}) begin
        errors++; $display("FAIL bounce_data: keyout=%h expected=%h", keyout, {12'd0, m_code});
      end
    end
  endtask

  task automatic test_capture_vs_ack();
    to_boundary();
    ack = 1'b0;
    keys = 16'h0000;
    repeat (2 * SCAN) tick();
    keys = 16'h0002;
    repeat (NEFF * SCAN - 1) tick();
    ack = 1'b1;
    tick();
    statusordata = 1'b1; #1;
    checks++;
    if (keyout !== 16'h0001) begin
      errors++; $display("FAIL cap_vs_ack_status: keyout=%h expected=0001", keyout);
    end
    statusordata = 1'b0; #1;
    checks++;
    if (keyout !== 16'h0002) begin
      errors++; $display("FAIL cap_vs_ack_data: keyout=%h expected=0002", keyout);
    end
    tick();
    statusordata = 1'b1; #1;
    checks++;
    if (keyout !== 16'h0001) begin
      errors++; $display("FAIL held_ack_status: keyout=%h expected=0001", keyout);
    end
    statusordata = 1'b0;
    ack = 1'b0;
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 40; seg++) begin
      int r;
      int n;
      to_boundary();
      r = $urandom_range(0, 99);
      if (r < 45)      keys = 16'h0000;
      else if (r < 85) keys = 16'h0001 << $urandom_range(0, 15);
      else             keys = 16'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n * SCAN; i++) begin
        if ($urandom_range(0, 5) == 0) ack = ~ack;
        tick();
        checks++;
        if (rowwrite !== exp_row()) begin
          errors++; $display("FAIL rand_row: rowwrite=%b expected=%b", rowwrite, exp_row());
        end
        statusordata = 1'b1; #1;
        checks++;
        if (keyout !== {15'd0, m_ready}) begin
          errors++; $display("FAIL rand_status: keyout=%h expected=%h", keyout, {15'd0, m_ready});
        end
        statusordata = 1'b0; #1;
        checks++;
        if (keyout !== {12'd0, m_code}) begin
          errors++; $display("FAIL rand_data: keyout=%h expected=%h", keyout, {12'd0, m_code});
        end
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_rows();
    test_capture();
    test_ack();
    test_star_and_multi();
    test_reset_mid_debounce();
    test_bounce();
    test_capture_vs_ack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
